// File: rtl/udp_protocol_rx.sv
`default_nettype none
// ============================================================================
// Module   : udp_protocol_rx
// Brief    : Receive-side UDP layer. Assembles the 8-byte UDP header from the
//            IP payload nibble stream (MII nibble order), latches the four
//            header fields, streams payload nibbles into the RX data FIFO and
//            reports datagram completion (rx_done) or failure (rx_err).
//            Optional destination-port filtering is compiled in with the
//            macro UDP_PORT_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module udp_protocol_rx #(
    parameter logic [15:0] LOCAL_PORT = 16'd8080,
    parameter int          LEN_W      = 16
) (
    input  logic             mii_tx_clk,
    input  logic             rst_n,
    input  logic             ip_dv,
    input  logic [3:0]       ip_da,
    input  logic             fifo_full,
    output logic             fifo_wr,
    output logic             fifo_ck,
    output logic [3:0]       fifo_da,
    output logic [15:0]      sour_port,
    output logic [15:0]      dest_port,
    output logic [LEN_W-1:0] udp_len,
    output logic [15:0]      udp_ck_sum,
    output logic             hdr_valid,
    output logic             rx_done,
    output logic             rx_err
);

    // Payload nibble counter holds (len - 8) * 2, one bit wider than the length.
    localparam int c_PCNT_W = LEN_W + 1;

`ifdef UDP_PORT_FILTER_EN
    localparam logic c_PORT_FILTER = 1'b1;
`else
    localparam logic c_PORT_FILTER = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_PAY  = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4,
        S_DROP = 3'd5
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [3:0]           r_hcnt;
    logic [3:0]           w_hcnt_nxt;
    logic [c_PCNT_W-1:0]  r_pcnt;
    logic [c_PCNT_W-1:0]  w_pcnt_nxt;
    logic                 r_armed_n;

    // Header assembly
    logic [15:0]          r_field;
    logic [15:0]          r_sour_asm;
    logic [15:0]          r_dest_asm;
    logic [LEN_W-1:0]     r_len_asm;
    logic [15:0]          w_field_done;
    logic                 w_nib_en;
    logic                 w_hdr_last;

    // Header decode
    logic                 w_len_short;
    logic                 w_len_empty;
    logic [LEN_W-1:0]     w_len_body;
    logic                 w_port_ok;

    // Registered outputs
    logic                 r_fifo_wr;
    logic [3:0]           r_fifo_da;
    logic [15:0]          r_sour_port;
    logic [15:0]          r_dest_port;
    logic [LEN_W-1:0]     r_udp_len;
    logic [15:0]          r_udp_ck_sum;
    logic                 r_hdr_valid;
    logic                 r_rx_done;
    logic                 r_rx_err;
    logic                 w_wr_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;

    // Fourth nibble of a field lands in [7:4]; the other three are already held.
    assign w_field_done = {r_field[15:8], ip_da, r_field[3:0]};

    assign w_len_short  = (r_len_asm <  LEN_W'(8));
    assign w_len_empty  = (r_len_asm == LEN_W'(8));
    assign w_len_body   = r_len_asm - LEN_W'(8);
    // Without filtering every destination port is accepted.
    assign w_port_ok    = !c_PORT_FILTER || (r_dest_asm == LOCAL_PORT);

    // Frame sequencing: next state, counters and end-of-frame pulses.
    always_comb begin
        w_next_state = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_pcnt_nxt   = r_pcnt;
        w_nib_en     = 1'b0;
        w_hdr_last   = 1'b0;
        w_wr_nxt     = 1'b0;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // Header nibble 0 is consumed in the transition cycle itself.
                if (ip_dv && !r_armed_n) begin
                    w_next_state = S_HDR;
                    w_nib_en     = 1'b1;
                    w_hcnt_nxt   = 4'd1;
                end
            end
            S_HDR: begin
                if (!ip_dv) begin
                    w_next_state = S_IDLE;
                    w_err_nxt    = 1'b1;
                    w_hcnt_nxt   = 4'd0;
                end else begin
                    w_nib_en   = 1'b1;
                    w_hcnt_nxt = r_hcnt + 4'd1;
                    if (r_hcnt == 4'd15) begin
                        w_hdr_last = 1'b1;
                        w_pcnt_nxt = '0;
                        if (w_len_short) begin
                            w_next_state = S_ERR;
                        end else if (!w_port_ok) begin
                            w_next_state = S_DROP;
                        end else if (w_len_empty) begin
                            w_next_state = S_DONE;
                        end else begin
                            w_next_state = S_PAY;
                            w_pcnt_nxt   = {w_len_body, 1'b0};
                        end
                    end
                end
            end
            S_PAY: begin
                if (!ip_dv) begin
                    // Datagram shorter than its length field claims.
                    w_next_state = S_IDLE;
                    w_err_nxt    = 1'b1;
                    w_pcnt_nxt   = '0;
                end else if (fifo_full) begin
                    // Drop this nibble; the partial frame is flagged at the end.
                    w_next_state = S_ERR;
                    w_pcnt_nxt   = '0;
                end else begin
                    w_wr_nxt   = 1'b1;
                    w_pcnt_nxt = r_pcnt - c_PCNT_W'(1);
                    if (r_pcnt == c_PCNT_W'(1)) begin
                        w_next_state = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // Ethernet pad nibbles are swallowed until ip_dv falls.
                if (!ip_dv) begin
                    w_next_state = S_IDLE;
                    w_done_nxt   = 1'b1;
                end
            end
            S_DROP, S_ERR: begin
                if (!ip_dv) begin
                    w_next_state = S_IDLE;
                    w_err_nxt    = 1'b1;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, counters, arming flag and the registered pulse/strobe outputs.
    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hcnt      <= 4'd0;
            r_pcnt      <= '0;
            r_armed_n   <= 1'b1;
            r_fifo_wr   <= 1'b0;
            r_fifo_da   <= 4'd0;
            r_hdr_valid <= 1'b0;
            r_rx_done   <= 1'b0;
            r_rx_err    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_hcnt      <= w_hcnt_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_fifo_wr   <= w_wr_nxt;
            r_hdr_valid <= w_hdr_last;
            r_rx_done   <= w_done_nxt;
            r_rx_err    <= w_err_nxt;
            // A frame already in flight at reset release is ignored until
            // ip_dv has been seen low once.
            if (!ip_dv) begin
                r_armed_n <= 1'b0;
            end
            if (w_wr_nxt) begin
                r_fifo_da <= ip_da;
            end
        end
    end

    // Header nibble assembly and field latching.
    always_ff @(posedge mii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_field      <= 16'd0;
            r_sour_asm   <= 16'd0;
            r_dest_asm   <= 16'd0;
            r_len_asm    <= '0;
            r_sour_port  <= 16'd0;
            r_dest_port  <= 16'd0;
            r_udp_len    <= '0;
            r_udp_ck_sum <= 16'd0;
        end else begin
            if (w_nib_en) begin
                // Wire order per field is [11:8], [15:12], [3:0], [7:4].
                case (r_hcnt[1:0])
                    2'd0: r_field[11:8]  <= ip_da;
                    2'd1: r_field[15:12] <= ip_da;
                    2'd2: r_field[3:0]   <= ip_da;
                    default: begin
                        case (r_hcnt[3:2])
                            2'd0:    r_sour_asm <= w_field_done;
                            2'd1:    r_dest_asm <= w_field_done;
                            2'd2:    r_len_asm  <= LEN_W'(w_field_done);
                            default: ;
                        endcase
                    end
                endcase
            end
            // All four fields become visible together with hdr_valid.
            if (w_hdr_last) begin
                r_sour_port  <= r_sour_asm;
                r_dest_port  <= r_dest_asm;
                r_udp_len    <= r_len_asm;
                r_udp_ck_sum <= w_field_done;
            end
        end
    end

    assign fifo_ck    = mii_tx_clk;
    assign fifo_wr    = r_fifo_wr;
    assign fifo_da    = r_fifo_da;
    assign sour_port  = r_sour_port;
    assign dest_port  = r_dest_port;
    assign udp_len    = r_udp_len;
    assign udp_ck_sum = r_udp_ck_sum;
    assign hdr_valid  = r_hdr_valid;
    assign rx_done    = r_rx_done;
    assign rx_err     = r_rx_err;

endmodule
`default_nettype wire
